bayer_stream_gen: RTL and testbench

// - Synthetic camera source: emits a raw Bayer pixel stream (X/Y counts, 12b data, DVAL), the same interface the image-processing block consumes from data capture.
// - Replaces the CCD capture path for bring-up and regression; selectable test patterns with deterministic, checkable values.

---
 rtl/bayer_stream_gen_pkg.sv | 43 ++++
 rtl/bayer_stream_gen_if.sv | 35 +++
 rtl/bayer_stream_gen_lfsr16.sv | 24 ++
 rtl/bayer_stream_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_bayer_stream_gen.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bayer_stream_gen_pkg.sv
// Shared types and constants for the synthetic Bayer camera source.
// Pattern modes, Bayer site decoding and the LFSR polynomial live here.
package bayer_stream_gen_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_CNT_W  = 11;

  // Right-shifting Fibonacci register: feedback from bits 0,2,3,5 realises
  // x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    MODE_FLAT = 2'd0,
    MODE_BARS = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_LFSR = 2'd3
  } mode_t;

  // Encoded as {Y[0], X[0]}.
  typedef enum logic [1:0] {
    SITE_GR = 2'b00,
    SITE_R  = 2'b01,
    SITE_B  = 2'b10,
    SITE_GB = 2'b11
  } bayer_site_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } gen_state_t;

  function automatic bayer_site_t bayer_site(input logic y0, input logic x0);
    return bayer_site_t'({y0, x0});
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/bayer_stream_gen_if.sv
// Raw Bayer pixel stream as consumed by the image-processing block.
// The source drives through the master modport, a sink reads via slave.
interface bayer_stream_gen_if
  import bayer_stream_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [CNT_W-1:0]  oX_Cont;
  logic [CNT_W-1:0]  oY_Cont;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic              oFRAME_DONE;
  logic [15:0]       oFrame_Cont;

  modport master (
    output oX_Cont,
    output oY_Cont,
    output oDATA,
    output oDVAL,
    output oFRAME_DONE,
    output oFrame_Cont
  );

  modport slave (
    input oX_Cont,
    input oY_Cont,
    input oDATA,
    input oDVAL,
    input oFRAME_DONE,
    input oFrame_Cont
  );

endinterface

// File: rtl/bayer_stream_gen_lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random test pattern source.
// Advances only when step is high; reseeded solely by reset.
module lfsr16
  import bayer_stream_gen_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_q <= LFSR_SEED;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bayer_stream_gen.sv
// Synthetic camera source: frame/line timing FSM plus test-pattern mux
// producing a registered raw Bayer stream with X/Y counts and DVAL.
module bayer_stream_gen
  import bayer_stream_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iFLAT,
  bayer_stream_gen_if.master o_vid
);

  localparam int LINE_CYC = H_ACTIVE + H_BLANK;
  localparam int VB_CYC   = V_BLANK * LINE_CYC;
  localparam int HB_W     = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam int VB_W     = (VB_CYC > 1) ? $clog2(VB_CYC) : 1;

  localparam logic [CNT_W-1:0]  X_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  Y_LAST  = CNT_W'(V_ACTIVE - 1);
  localparam logic [HB_W-1:0]   HB_LAST = HB_W'(H_BLANK - 1);
  localparam logic [VB_W-1:0]   VB_LAST = VB_W'(VB_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [HB_W-1:0]   HB_ONE  = HB_W'(1);
  localparam logic [VB_W-1:0]   VB_ONE  = VB_W'(1);
  localparam logic [DATA_W-1:0] MAXV    = '1;

  gen_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_x, w_x_nxt;
  logic [CNT_W-1:0]  r_y, w_y_nxt;
  logic [HB_W-1:0]   r_hcnt, w_hcnt_nxt;
  logic [VB_W-1:0]   r_vcnt, w_vcnt_nxt;
  mode_t             r_mode, w_mode_nxt;
  logic [DATA_W-1:0] r_flat, w_flat_nxt;
  logic              w_dval_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [15:0]       w_lfsr_q;

  logic [DATA_W-1:0] r_data;
  logic              r_dval;
  logic              r_done;
  logic [15:0]       r_frames;

  // Colour-bar index X*8/H_ACTIVE, found by threshold compares so no divider is built.
  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] x);
    logic [2:0] b;
    b = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x) * 8 >= k * H_ACTIVE) b = 3'(k);
    end
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] pixel(
    input mode_t             m,
    input logic [CNT_W-1:0]  x,
    input logic              y0,
    input logic [DATA_W-1:0] flat,
    input logic [DATA_W-1:0] rnd
  );
    logic [2:0]        b;
    logic [DATA_W-1:0] v;
    b = bar_idx(x);
    v = '0;
    case (m)
      MODE_FLAT: v = flat;
      MODE_BARS: begin
        case (bayer_site(y0, x[0]))
          SITE_R:  v = b[2] ? MAXV : '0;
          SITE_B:  v = b[0] ? MAXV : '0;
          default: v = b[1] ? MAXV : '0;
        endcase
      end
      MODE_RAMP: v = DATA_W'(x);
      MODE_LFSR: v = rnd;
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Next-cycle view of the stream: everything below is what the outputs show after this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_mode_nxt  = r_mode;
    w_flat_nxt  = r_flat;
    w_dval_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_x_nxt = '0;
        w_y_nxt = '0;
        if (iEN) begin
          w_state_nxt = ST_ACTIVE;
          w_dval_nxt  = 1'b1;
          w_mode_nxt  = mode_t'(iMODE);
          w_flat_nxt  = iFLAT;
        end
      end

      ST_ACTIVE: begin
        if (r_x == X_LAST) begin
          w_state_nxt = ST_HBLANK;
          w_hcnt_nxt  = '0;
        end else begin
          w_x_nxt    = r_x + CNT_ONE;
          w_dval_nxt = 1'b1;
        end
      end

      ST_HBLANK: begin
        if (r_hcnt == HB_LAST) begin
          if (r_y < Y_LAST) begin
            w_state_nxt = ST_ACTIVE;
            w_x_nxt     = '0;
            w_y_nxt     = r_y + CNT_ONE;
            w_dval_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_VBLANK;
            w_vcnt_nxt  = '0;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + HB_ONE;
        end
      end

      ST_VBLANK: begin
        if (r_vcnt == VB_LAST) begin
          w_x_nxt = '0;
          w_y_nxt = '0;
          // Enable is only honoured here, so frames are never truncated.
          if (iEN) begin
            w_state_nxt = ST_ACTIVE;
            w_dval_nxt  = 1'b1;
            w_mode_nxt  = mode_t'(iMODE);
            w_flat_nxt  = iFLAT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_vcnt_nxt = r_vcnt + VB_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
      end
    endcase
  end

  assign w_done_nxt = (w_state_nxt == ST_VBLANK) && (w_vcnt_nxt == VB_LAST);
  assign w_data_nxt = w_dval_nxt
                    ? pixel(w_mode_nxt, w_x_nxt, w_y_nxt[0], w_flat_nxt, DATA_W'(w_lfsr_q))
                    : '0;

  // The LFSR value shown with a pixel is the current one; it advances past it on the same edge.
  lfsr16 u_lfsr (
    .iCLK (iCLK),
    .iRST (iRST),
    .step (w_dval_nxt),
    .q    (w_lfsr_q)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_mode   <= MODE_FLAT;
      r_flat   <= '0;
      r_data   <= '0;
      r_dval   <= 1'b0;
      r_done   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      r_mode <= w_mode_nxt;
      r_flat <= w_flat_nxt;
      r_data <= w_data_nxt;
      r_dval <= w_dval_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign o_vid.oX_Cont     = r_x;
  assign o_vid.oY_Cont     = r_y;
  assign o_vid.oDATA       = r_data;
  assign o_vid.oDVAL       = r_dval;
  assign o_vid.oFRAME_DONE = r_done;
  assign o_vid.oFrame_Cont = r_frames;

endmodule

// File: tb/tb_bayer_stream_gen.sv
// Scoreboard bench for bayer_stream_gen on a small 8x4 frame: expected pixels
// are queued from a reference model and popped as DVAL samples arrive.
module tb_bayer_stream_gen;

  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int HB    = 2;
  localparam int VB    = 1;
  localparam int DW    = 12;
  localparam int CW    = 11;
  localparam int LINE  = HA + HB;
  localparam int FRAME = (VA + VB) * LINE;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] flat;

  always #5 clk = ~clk;

  bayer_stream_gen_if #(.DATA_W(DW), .CNT_W(CW)) vid ();

  bayer_stream_gen #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_BLANK  (VB),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .iCLK  (clk),
    .iRST  (rst),
    .iEN   (en),
    .iMODE (mode),
    .iFLAT (flat),
    .o_vid (vid)
  );

  typedef struct {
    int            x;
    int            y;
    logic [DW-1:0] d;
  } pix_t;

  pix_t        sb[$];
  logic [15:0] m_lfsr;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [DW-1:0] model_pix(int md, logic [DW-1:0] fv, int x, int y);
    int            b;
    logic [DW-1:0] maxv;
    logic [31:0]   xv;
    maxv = '1;
    b    = (x * 8) / HA;
    xv   = x;
    case (md)
      0: return fv;
      1: begin
        if ((y % 2 == 0) && (x % 2 == 1)) return ((b / 4) % 2 == 1) ? maxv : '0;
        if ((y % 2 == 1) && (x % 2 == 0)) return (b % 2 == 1) ? maxv : '0;
        return ((b / 2) % 2 == 1) ? maxv : '0;
      end
      2: return xv[DW-1:0];
      default: return '0;
    endcase
  endfunction

  task automatic push_frame(int md, logic [DW-1:0] fv);
    pix_t p;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        p.x = x;
        p.y = y;
        if (md == 3) begin
          p.d    = m_lfsr[DW-1:0];
          m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end else begin
          p.d = model_pix(md, fv, x, y);
        end
        sb.push_back(p);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA, vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d x=%0d y=%0d d=%h dval=%b done=%b frames=%0d, all must be 0",
                 c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flat();
    pix_t p;
    logic exp_dval;
    int   nval = 0;
    mode = 2'd0;
    flat = 12'h5A5;
    push_frame(0, 12'h5A5);
    en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FRAME + 10; c++) begin
      if (c == 0) en = 1'b0;
      exp_dval = (c < VA * LINE) && ((c % LINE) < HA);
      n_checks++;
      if (vid.oDVAL !== exp_dval) begin
        n_fail++;
        $display("FAIL flat_dval c=%0d got %b need %b", c, vid.oDVAL, exp_dval);
      end
      if (vid.oDVAL === 1'b1) begin
        nval++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL flat_underflow c=%0d unexpected pixel x=%0d y=%0d", c, vid.oX_Cont, vid.oY_Cont);
        end else begin
          p = sb.pop_front();
          if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA} !== {CW'(p.x), CW'(p.y), p.d}) begin
            n_fail++;
            $display("FAIL flat_pix c=%0d got x=%0d y=%0d d=%h need x=%0d y=%0d d=%h",
                     c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, p.x, p.y, p.d);
          end
        end
      end else begin
        n_checks++;
        if (vid.oDATA !== '0) begin
          n_fail++;
          $display("FAIL flat_blank_data c=%0d got %h need 000", c, vid.oDATA);
        end
      end
      if ((c < VA * LINE) && ((c % LINE) >= HA)) begin
        n_checks++;
        if ({vid.oX_Cont, vid.oY_Cont} !== {CW'(HA - 1), CW'(c / LINE)}) begin
          n_fail++;
          $display("FAIL flat_hblank_hold c=%0d got x=%0d y=%0d need x=%0d y=%0d",
                   c, vid.oX_Cont, vid.oY_Cont, HA - 1, c / LINE);
        end
      end
      n_checks++;
      if ({vid.oFRAME_DONE, vid.oFrame_Cont} !== {(c == FRAME - 1), 16'((c >= FRAME - 1) ? 1 : 0)}) begin
        n_fail++;
        $display("FAIL flat_done c=%0d got done=%b frames=%0d need done=%b frames=%0d",
                 c, vid.oFRAME_DONE, vid.oFrame_Cont, (c == FRAME - 1), (c >= FRAME - 1) ? 1 : 0);
      end
      @(negedge clk);
    end
    n_checks++;
    if (nval != VA * HA || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flat_count got %0d pixels left %0d need %0d left 0", nval, sb.size(), VA * HA);
    end
  endtask

  task automatic test_bars();
    pix_t p;
    // Hand-derived samples: {x, y, value}.
    int spot[6][3] = '{'{0, 0, 0}, '{1, 0, 0}, '{4, 0, 0}, '{5, 0, 'hFFF}, '{0, 1, 0}, '{7, 1, 'hFFF}};
    mode = 2'd1;
    push_frame(1, '0);
    en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FRAME + 5; c++) begin
      if (c == 0) en = 1'b0;
      if (vid.oDVAL === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bars_underflow c=%0d unexpected pixel", c);
        end else begin
          p = sb.pop_front();
          if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA} !== {CW'(p.x), CW'(p.y), p.d}) begin
            n_fail++;
            $display("FAIL bars_pix c=%0d got x=%0d y=%0d d=%h need x=%0d y=%0d d=%h",
                     c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, p.x, p.y, p.d);
          end
        end
        for (int s = 0; s < 6; s++) begin
          if (int'(vid.oX_Cont) == spot[s][0] && int'(vid.oY_Cont) == spot[s][1]) begin
            n_checks++;
            if (vid.oDATA !== DW'(spot[s][2])) begin
              n_fail++;
              $display("FAIL bars_spot x=%0d y=%0d got %h need %h",
                       spot[s][0], spot[s][1], vid.oDATA, DW'(spot[s][2]));
            end
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0 || vid.oFrame_Cont !== 16'd2) begin
      n_fail++;
      $display("FAIL bars_end left %0d frames %0d need left 0 frames 2", sb.size(), vid.oFrame_Cont);
    end
  endtask

  task automatic test_back_to_back_ramp();
    pix_t p;
    logic exp_dval;
    logic exp_done;
    mode = 2'd2;
    for (int f = 0; f < 4; f++) push_frame(2, '0);
    en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4 * FRAME + 10; c++) begin
      if (c == 3 * FRAME) en = 1'b0;
      exp_dval = (c < 4 * FRAME) && ((c % FRAME) < VA * LINE) && ((c % LINE) < HA);
      exp_done = (c < 4 * FRAME) && ((c % FRAME) == FRAME - 1);
      n_checks++;
      if ({vid.oDVAL, vid.oFRAME_DONE} !== {exp_dval, exp_done}) begin
        n_fail++;
        $display("FAIL ramp_timing c=%0d got dval=%b done=%b need dval=%b done=%b",
                 c, vid.oDVAL, vid.oFRAME_DONE, exp_dval, exp_done);
      end
      if (vid.oDVAL === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ramp_underflow c=%0d unexpected pixel", c);
        end else begin
          p = sb.pop_front();
          if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA} !== {CW'(p.x), CW'(p.y), p.d}) begin
            n_fail++;
            $display("FAIL ramp_pix c=%0d got x=%0d y=%0d d=%h need x=%0d y=%0d d=%h",
                     c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, p.x, p.y, p.d);
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0 || vid.oFrame_Cont !== 16'd4) begin
      n_fail++;
      $display("FAIL ramp_end left %0d frames %0d need left 0 frames 4", sb.size(), vid.oFrame_Cont);
    end
  endtask

  task automatic test_lfsr();
    pix_t p;
    m_lfsr = 16'hACE1;
    mode   = 2'd3;
    push_frame(3, '0);
    en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FRAME + 5; c++) begin
      if (c == 0) begin
        en = 1'b0;
        n_checks++;
        if (vid.oDATA !== 12'hCE1) begin
          n_fail++;
          $display("FAIL lfsr_seed got %h need ce1", vid.oDATA);
        end
      end
      if (vid.oDVAL === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL lfsr_underflow c=%0d unexpected pixel", c);
        end else begin
          p = sb.pop_front();
          if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA} !== {CW'(p.x), CW'(p.y), p.d}) begin
            n_fail++;
            $display("FAIL lfsr_pix c=%0d got x=%0d y=%0d d=%h need x=%0d y=%0d d=%h",
                     c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, p.x, p.y, p.d);
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0 || vid.oFrame_Cont !== 16'd1) begin
      n_fail++;
      $display("FAIL lfsr_end left %0d frames %0d need left 0 frames 1", sb.size(), vid.oFrame_Cont);
    end
  endtask

  task automatic test_en_drop();
    pix_t p;
    logic exp_dval;
    mode = 2'd0;
    flat = 12'h123;
    push_frame(0, 12'h123);
    en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FRAME + 20; c++) begin
      exp_dval = (c < VA * LINE) && ((c % LINE) < HA);
      n_checks++;
      if ({vid.oDVAL, vid.oFRAME_DONE} !== {exp_dval, (c == FRAME - 1)}) begin
        n_fail++;
        $display("FAIL drop_timing c=%0d got dval=%b done=%b need dval=%b done=%b",
                 c, vid.oDVAL, vid.oFRAME_DONE, exp_dval, (c == FRAME - 1));
      end
      if (vid.oDVAL === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL drop_underflow c=%0d unexpected pixel", c);
        end else begin
          p = sb.pop_front();
          if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA} !== {CW'(p.x), CW'(p.y), p.d}) begin
            n_fail++;
            $display("FAIL drop_pix c=%0d got x=%0d y=%0d d=%h need x=%0d y=%0d d=%h",
                     c, vid.oX_Cont, vid.oY_Cont, vid.oDATA, p.x, p.y, p.d);
          end
        end
      end
      if (c == LINE + 3) begin
        en   = 1'b0;
        mode = 2'd2;
        flat = 12'hFFF;
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0 || vid.oFrame_Cont !== 16'd2) begin
      n_fail++;
      $display("FAIL drop_end left %0d frames %0d need left 0 frames 2", sb.size(), vid.oFrame_Cont);
    end
  endtask

  task automatic test_reset_midline();
    logic exp_dval;
    mode = 2'd2;
    en   = 1'b1;
    @(negedge clk);
    for (int c = 0; c < LINE + 3; c++) begin
      exp_dval = (c % LINE) < HA;
      n_checks++;
      if (vid.oDVAL !== exp_dval) begin
        n_fail++;
        $display("FAIL midrst_pre c=%0d got dval=%b need %b", c, vid.oDVAL, exp_dval);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({vid.oX_Cont, vid.oY_Cont, vid.oDATA, vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont} !== '0) begin
      n_fail++;
      $display("FAIL midrst_state x=%0d y=%0d d=%h dval=%b done=%b frames=%0d, all must be 0",
               vid.oX_Cont, vid.oY_Cont, vid.oDATA, vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont);
    end
    rst = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if ({vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont} !== '0) begin
        n_fail++;
        $display("FAIL midrst_idle c=%0d got dval=%b done=%b frames=%0d need 0 0 0",
                 c, vid.oDVAL, vid.oFRAME_DONE, vid.oFrame_Cont);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    mode   = 2'd0;
    flat   = '0;
    m_lfsr = 16'hACE1;
    test_reset();
    test_flat();
    test_bars();
    do_reset();
    test_back_to_back_ramp();
    do_reset();
    test_lfsr();
    test_en_drop();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
